ext_sram_arbiter: RTL
=====================

# ext_sram_arbiter

Word-level sequencer and arbiter for the single byte-wide external SRAM port. Two word requesters use the same req/gnt/rvalid protocol as the core memory interface: port 0 is the MMU/core side and port 1 is the loader/DMA side. The block selects one requester, latches its request and runs four byte beats on the SRAM. It returns the assembled read word, or a write completion, with a one-cycle `rvalid`.

## Interface
- `SRAM_ADDR_MASK`, default 32'hFFFF_FFFF: ANDed onto every outgoing byte address.
- `clk` in 1: sole clock, rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `p0_req_i`, `p1_req_i` in 1 each: word request, held high until granted.
- `p0_gnt_o`, `p1_gnt_o` out 1 each: request accepted; single-cycle pulse.
- `p0_rvalid_o`, `p1_rvalid_o` out 1 each: completion pulse, for both read and write.
- `p0_we_i`, `p1_we_i` in 1 each: 1 = write, 0 = read.
- `p0_be_i`, `p1_be_i` in 4 each: byte enables, used for writes only.
- `p0_addr_i`, `p1_addr_i` in 32 each: byte address of byte 0.
- `p0_wdata_i`, `p1_wdata_i` in 32 each: write word; byte k is `[8k+7:8k]`.
- `p0_rdata_o`, `p1_rdata_o` out 32 each: both driven from one shared read buffer; meaningful only while the owner's `rvalid` is high.
- `ext_sram_rdata_i` in 8: read byte, valid the cycle after `ext_sram_read_o`.
- `ext_sram_wdata_o` out 8: write byte.
- `ext_sram_addr_o` out 32: byte address.
- `ext_sram_read_o` out 1: read strobe.
- `ext_sram_write_o` out 1: write strobe.

## Operation
- States: IDLE, ACCESS, DRAIN, RESP. A 2-bit beat counter runs 0..3.
- IDLE
  - If any `req` is high, pick a winner and assert its `gnt_o` combinationally in that cycle.
  - On the clock edge, latch the winner's `we`, `be`, `addr` and `wdata`, plus the owner ID. Clear the beat counter and go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS, beat k
  - `ext_sram_addr_o = (addr_q + k) & SRAM_ADDR_MASK`. The addition is 32-bit modulo 2^32, so FFFF_FFFF + 1 wraps to 0.
  - Read: `ext_sram_read_o = 1`.
  - Write: `ext_sram_write_o = be_q[k]` and `ext_sram_wdata_o = wdata_q[8k+:8]`. A beat with its enable low still takes one cycle.
  - After k = 3: a read goes to DRAIN, a write goes to RESP.
- Read capture: the byte of beat k is present on `ext_sram_rdata_i` during the cycle after beat k. It is written into `rbuf[8k+:8]` at the end of that cycle. Beats 0..2 are captured during ACCESS; beat 3 is captured in DRAIN.
- DRAIN: SRAM strobes are 0. Capture byte 3, then go to RESP.
- RESP
  - The owner's `rvalid_o` is high for exactly one cycle, then go to IDLE.
  - No arbitration happens in RESP; the next grant can come no earlier than the following IDLE cycle.
  - `rbuf` holds its value until the next read transaction overwrites it. Writes do not modify it.
- Arbitration: a `last_grant` register is updated on each grant (see Configuration).
- Requests arriving outside IDLE are not granted; they wait, with `req` held.
- A `req` dropped before grant is simply not served. This is not an error.

## Timing
- Grant in cycle T.
- Write: beats at T+1..T+4, `rvalid` at T+5, next grant at T+6 at the earliest, so 6 cycles per word.
- Read: beats at T+1..T+4, DRAIN at T+5, `rvalid` with the full word at T+6, next grant at T+7 at the earliest.
- Outside ACCESS, `ext_sram_addr_o`, `ext_sram_wdata_o`, `ext_sram_read_o` and `ext_sram_write_o` are 0.
- Reset values: every output is 0; state is IDLE, beat counter is 0, `rbuf` is 0 and `last_grant` is 1.
- Reset mid-transaction: the transfer is abandoned with no `rvalid`. SRAM strobes are 0 from the first cycle after the reset edge. The requester must reissue.
- Reset held high: no grants.

## Configuration
- `SRAM_ARB_RR_EN` defined: round-robin.
  - On simultaneous requests, the port that was not granted last wins.
  - A single request wins regardless of history.
  - `last_grant` records the winner. Its reset value of 1 makes port 0 win the first tie.
- `SRAM_ARB_RR_EN` undefined: fixed priority, port 0 always wins ties. `last_grant` is unused and may be optimized away.

## Test plan
- Port 0 read, `addr` = 0x100, SRAM model bytes 0x100..0x103 = 11,22,33,44:
  - `p0_gnt_o` pulses at T.
  - Read strobes at 0x100..0x103 during T+1..T+4.
  - `p0_rvalid_o` at T+6 with `p0_rdata_o` = 0x44332211.
  - `p1_rvalid_o` stays 0.
- Port 1 write, `addr` = 0x200, `wdata` = 0xAABBCCDD, `be` = 4'b0101:
  - `ext_sram_write_o` high only at beats 0 and 2, with data DD at 0x200 and BB at 0x202.
  - `p1_rvalid_o` at T+5.
  - A readback by port 0 shows bytes 1 and 3 unchanged.
- Both ports request continuously for three reads, with `SRAM_ARB_RR_EN` defined:
  - Grant order is 0, 1, 0.
  - Each grant comes 7 cycles after the previous one.
- Same stimulus with `SRAM_ARB_RR_EN` undefined:
  - Grant order is 0, 0, 0.
  - Port 1 is granted only after `p0_req_i` drops.
- `addr` = 0xFFFF_FFFE read with `SRAM_ADDR_MASK` = 0x0000_FFFF: byte addresses are FFFE, FFFF, 0000, 0001.
- `rst_i` pulsed in the cycle of beat 2 of a port 0 read:
  - No `rvalid`; all outputs 0 from the next cycle.
  - A tie afterwards is granted to port 0.

Source files
------------

// File: rtl/ext_sram_arbiter_if.sv
// Bundles both word requester ports and the byte-wide external SRAM port.
// The arbiter takes the slave modport; the requesters and the SRAM drive the master side.
interface ext_sram_arbiter_if;
    logic        p0_req_i, p1_req_i;
    logic        p0_gnt_o, p1_gnt_o;
    logic        p0_rvalid_o, p1_rvalid_o;
    logic        p0_we_i, p1_we_i;
    logic [3:0]  p0_be_i, p1_be_i;
    logic [31:0] p0_addr_i, p1_addr_i;
    logic [31:0] p0_wdata_i, p1_wdata_i;
    logic [31:0] p0_rdata_o, p1_rdata_o;
    logic [7:0]  ext_sram_rdata_i;
    logic [7:0]  ext_sram_wdata_o;
    logic [31:0] ext_sram_addr_o;
    logic        ext_sram_read_o, ext_sram_write_o;

    modport slave (
        input  p0_req_i, p1_req_i, p0_we_i, p1_we_i, p0_be_i, p1_be_i,
               p0_addr_i, p1_addr_i, p0_wdata_i, p1_wdata_i, ext_sram_rdata_i,
        output p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o, p0_rdata_o, p1_rdata_o,
               ext_sram_wdata_o, ext_sram_addr_o, ext_sram_read_o, ext_sram_write_o
    );

    modport master (
        output p0_req_i, p1_req_i, p0_we_i, p1_we_i, p0_be_i, p1_be_i,
               p0_addr_i, p1_addr_i, p0_wdata_i, p1_wdata_i, ext_sram_rdata_i,
        input  p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o, p0_rdata_o, p1_rdata_o,
               ext_sram_wdata_o, ext_sram_addr_o, ext_sram_read_o, ext_sram_write_o
    );
endinterface

// File: rtl/ext_sram_arbiter.sv
// Arbitrates two word requesters onto a byte-wide SRAM as four byte beats; SRAM_ARB_RR_EN selects round-robin.
// Latency: grant T, write rvalid T+5, read rvalid T+6 (extra DRAIN cycle captures the last byte).
// Backpressure: requests are held until granted; grants only happen in IDLE, one word in flight.
module ext_sram_arbiter #(
    parameter logic [31:0] SRAM_ADDR_MASK = 32'hFFFF_FFFF
) (
    input logic               clk,
    input logic               rst_i,
    ext_sram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, RESP} state_t;

    state_t      state;
    logic [1:0]  beat;
    logic        owner;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rbuf;
    logic        any_req;
    logic        grant;
    logic        pick1;
    logic        access;
    logic [1:0]  cap_k;

    assign any_req = bus.p0_req_i || bus.p1_req_i;
    assign grant   = (state == IDLE) && !rst_i && any_req;

`ifdef SRAM_ARB_RR_EN
    logic last_grant;

    // On a tie the port that did not win last time goes first.
    assign pick1 = bus.p1_req_i && (!bus.p0_req_i || !last_grant);

    always_ff @(posedge clk) begin
        if (rst_i)
            last_grant <= 1'b1;
        else if (grant)
            last_grant <= pick1;
    end
`else
    assign pick1 = bus.p1_req_i && !bus.p0_req_i;
`endif

    // Byte of beat k arrives one cycle after its strobe, so ACCESS captures the previous beat.
    assign cap_k = beat - 2'd1;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state   <= IDLE;
            beat    <= 2'd0;
            owner   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rbuf    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner   <= pick1;
                        we_q    <= pick1 ? bus.p1_we_i    : bus.p0_we_i;
                        be_q    <= pick1 ? bus.p1_be_i    : bus.p0_be_i;
                        addr_q  <= pick1 ? bus.p1_addr_i  : bus.p0_addr_i;
                        wdata_q <= pick1 ? bus.p1_wdata_i : bus.p0_wdata_i;
                        beat    <= 2'd0;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!we_q && beat != 2'd0)
                        rbuf[{cap_k, 3'b000} +: 8] <= bus.ext_sram_rdata_i;
                    if (beat == 2'd3)
                        state <= we_q ? RESP : DRAIN;
                    else
                        beat <= beat + 2'd1;
                end
                DRAIN: begin
                    rbuf[31:24] <= bus.ext_sram_rdata_i;
                    state       <= RESP;
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign access = (state == ACCESS);

    assign bus.p0_gnt_o    = grant && !pick1;
    assign bus.p1_gnt_o    = grant && pick1;
    assign bus.p0_rvalid_o = (state == RESP) && !owner;
    assign bus.p1_rvalid_o = (state == RESP) && owner;
    assign bus.p0_rdata_o  = rbuf;
    assign bus.p1_rdata_o  = rbuf;

    assign bus.ext_sram_addr_o  = access ? ((addr_q + {30'd0, beat}) & SRAM_ADDR_MASK) : 32'd0;
    assign bus.ext_sram_read_o  = access && !we_q;
    assign bus.ext_sram_write_o = access && we_q && be_q[beat];
    assign bus.ext_sram_wdata_o = (access && we_q) ? wdata_q[{beat, 3'b000} +: 8] : 8'd0;
endmodule
